// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared opcode, field and state definitions for the instruction emitter
package instr_pkg;

    localparam logic [3:0] OP_0   = 4'd0;
    localparam logic [3:0] OP_1   = 4'd1;
    localparam logic [3:0] OP_2   = 4'd2;
    localparam logic [3:0] OP_3   = 4'd3;
    localparam logic [3:0] OP_4   = 4'd4;
    localparam logic [3:0] OP_5   = 4'd5;
    localparam logic [3:0] OP_6   = 4'd6;
    localparam logic [3:0] OP_7   = 4'd7;
    localparam logic [3:0] OP_8   = 4'd8;
    localparam logic [3:0] OP_9   = 4'd9;
    localparam logic [3:0] OP_10  = 4'd10;
    localparam logic [3:0] OP_MAX = 4'd10;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RC_MSB  = 11;
    localparam int RC_LSB  = 8;
    localparam int RA_MSB  = 7;
    localparam int RA_LSB  = 4;
    localparam int RB_MSB  = 3;
    localparam int RB_LSB  = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } emit_state_e;

endpackage

// File: rtl/instr_emitter_debounce_pulse.sv
// rtl/instr_emitter_debounce_pulse.sv - button synchronizer and debouncer emitting one pulse per press
module debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            // Counter saturates so a held button fires once, on its final step.
            cnt_d   = cnt_q + CNT_W'(1);
            pulse_d = (cnt_q == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/instr_emitter.sv
// rtl/instr_emitter.sv - front-panel instruction FIFO issuing words over a valid/ready handshake
module instr_emitter
    import instr_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        key_load_n,
    input  logic        key_run_n,
    input  logic [15:0] sw_instr,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [4:0]  count,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        err_overflow,
    output logic        err_opcode
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic load_pulse;
    logic run_pulse;

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .key_n   (key_load_n),
        .pulse   (load_pulse)
    );

    debounce_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .key_n   (key_run_n),
        .pulse   (run_pulse)
    );

    emit_state_e      state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [4:0]       count_q, count_d;
    logic [15:0]      instr_q, instr_d;
    logic             err_overflow_q, err_overflow_d;
    logic             err_opcode_q, err_opcode_d;
    logic [15:0]      mem_q [DEPTH];
    logic [15:0]      mem_d [DEPTH];

    logic full_w, empty_w, opc_ok, push, pop;

    always_comb begin
        full_w     = (count_q == DEPTH_C);
        empty_w    = (count_q == 5'd0);
        opc_ok     = (sw_instr[OPC_MSB:OPC_LSB] <= OP_MAX);
        pop        = (state_q == ISSUE) && instr_ready;
        push       = load_pulse && opc_ok && (!full_w || pop);
        rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        instr_d        = instr_q;
        mem_d          = mem_q;
        err_opcode_d   = err_opcode_q | (load_pulse & ~opc_ok);
        err_overflow_d = err_overflow_q | (load_pulse & opc_ok & full_w & ~pop);

        if (push) begin
            mem_d[wr_ptr_q] = sw_instr;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_nxt;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (run_pulse && !empty_w) begin
                    state_d = ISSUE;
                    instr_d = mem_q[rd_ptr_q];
                end
            end
            ISSUE: begin
                if (pop) begin
                    // With one entry left, a same-cycle push becomes the new head directly.
                    instr_d = (count_q == 5'd1 && push) ? sw_instr : mem_q[rd_ptr_nxt];
                end
                if (run_pulse || (pop && count_q == 5'd1 && !push)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= 5'd0;
            instr_q        <= 16'h0000;
            err_overflow_q <= 1'b0;
            err_opcode_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            instr_q        <= instr_d;
            err_overflow_q <= err_overflow_d;
            err_opcode_q   <= err_opcode_d;
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge CLOCK_50) begin
        mem_q <= mem_d;
    end

    assign instr        = instr_q;
    assign instr_valid  = (state_q == ISSUE);
    assign busy         = (state_q == ISSUE);
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign err_overflow = err_overflow_q;
    assign err_opcode   = err_opcode_q;

endmodule

// File: tb/tb_instr_emitter.sv
// tb/tb_instr_emitter.sv - directed self-checking bench for instr_emitter
module tb_instr_emitter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        key_load_n;
    logic        key_run_n;
    logic [15:0] sw_instr;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        busy;
    logic        err_overflow;
    logic        err_opcode;

    int checks = 0;
    int errors = 0;

    instr_emitter #(.DEPTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50     (clk),
        .reset_n      (reset_n),
        .key_load_n   (key_load_n),
        .key_run_n    (key_run_n),
        .sw_instr     (sw_instr),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_opcode   (err_opcode)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [15:0] w);
        sw_instr   = w;
        key_load_n = 1'b0;
        repeat (10) @(negedge clk);
        key_load_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_press(input string tag);
        bit seen = 1'b0;
        key_run_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic run_release();
        key_run_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        key_load_n  = 1'b1;
        key_run_n   = 1'b1;
        sw_instr    = 16'h0000;
        instr_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // reset state
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flags", {26'd0, empty, full, busy, instr_valid, err_overflow, err_opcode}, 32'b100000);
        chk("rst_instr", 32'(instr), 32'h0000);

        // two words issued back to back
        load_word(16'h0123);
        load_word(16'h6A45);
        chk("t1_count", 32'(count), 32'd2);
        instr_ready = 1'b1;
        run_press("t1_busy");
        chk("t1_first", {15'd0, instr_valid, instr}, {15'd0, 1'b1, 16'h0123});
        @(negedge clk);
        chk("t1_second", {15'd0, busy, instr}, {15'd0, 1'b1, 16'h6A45});
        @(negedge clk);
        chk("t1_done", {25'd0, busy, instr_valid, count}, {25'd0, 1'b0, 1'b0, 5'd0});
        run_release();

        // illegal then maximal legal opcode
        load_word(16'hB000);
        chk("t2_bad_count", 32'(count), 32'd0);
        chk("t2_err_opcode", 32'(err_opcode), 32'd1);
        load_word(16'hA000);
        chk("t2_good_count", 32'(count), 32'd1);
        run_press("t2_busy");
        chk("t2_instr", 32'(instr), 32'h0000A000);
        @(negedge clk);
        chk("t2_drained", {26'd0, busy, count}, 32'd0);
        run_release();

        // fill, overflow, stall, then drain in order
        instr_ready = 1'b0;
        load_word(16'h1001);
        load_word(16'h2002);
        load_word(16'h3003);
        load_word(16'h4004);
        chk("t3_full4", {25'd0, full, err_overflow, count}, {25'd0, 1'b1, 1'b0, 5'd4});
        load_word(16'h5005);
        chk("t3_overflow", {25'd0, full, err_overflow, count}, {25'd0, 1'b1, 1'b1, 5'd4});
        run_press("t3_busy");
        for (int i = 0; i < 10; i++) begin
            chk("t4_stall", {15'd0, instr_valid, instr}, {15'd0, 1'b1, 16'h1001});
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        chk("t3_drain2", {11'd0, count, instr}, {11'd0, 5'd3, 16'h2002});
        @(negedge clk);
        chk("t3_drain3", {11'd0, count, instr}, {11'd0, 5'd2, 16'h3003});
        @(negedge clk);
        chk("t3_drain4", {11'd0, count, instr}, {11'd0, 5'd1, 16'h4004});
        @(negedge clk);
        chk("t3_idle", {25'd0, busy, instr_valid, count}, 32'd0);
        run_release();

        // glitch is filtered, long hold gives one push
        sw_instr   = 16'h7777;
        key_load_n = 1'b0;
        repeat (2) @(negedge clk);
        key_load_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t5_glitch", 32'(count), 32'd0);
        key_load_n = 1'b0;
        repeat (100) @(negedge clk);
        key_load_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_hold", 32'(count), 32'd1);

        do_reset();
        chk("t6_rst_clear", {25'd0, err_overflow, err_opcode, count}, 32'd0);

        // full FIFO in ISSUE: simultaneous pop and load keeps count
        instr_ready = 1'b0;
        load_word(16'h7777);
        load_word(16'h8008);
        load_word(16'h9009);
        load_word(16'h0AAA);
        run_press("t6_busy");
        chk("t6_head", {10'd0, full, count, instr}, {10'd0, 1'b1, 5'd4, 16'h7777});
        sw_instr   = 16'h0BBB;
        key_load_n = 1'b0;
        repeat (6) @(negedge clk);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("t6_pushpop", {10'd0, err_overflow, count, instr}, {10'd0, 1'b0, 5'd4, 16'h8008});
        key_load_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t6_still_busy", {26'd0, busy, count}, {26'd0, 1'b1, 5'd4});

        // reset while issuing
        reset_n = 1'b0;
        @(negedge clk);
        chk("t7_rst_count", 32'(count), 32'd0);
        chk("t7_rst_flags", {26'd0, empty, full, busy, instr_valid, err_overflow, err_opcode}, 32'b100000);
        chk("t7_rst_instr", 32'(instr), 32'h0000);
        reset_n = 1'b1;
        run_release();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_emitter.md
# instr_emitter

Front-panel instruction source for the processor datapath. It debounces the load and run push-buttons, queues 16-bit instruction words taken from the switches into an internal FIFO, and, on command, issues them one per valid/ready handshake to the datapath's instruction input. Opcode legality is checked at load time, so only opcodes 0–10 ever reach the datapath.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16
- DEBOUNCE_CYCLES, 500000, stable-input cycles required before a press is accepted (10 ms at 50 MHz)

Ports:
- CLOCK_50  input  1  sole clock
- reset_n  input  1  synchronous, active-low reset
- key_load_n  input  1  raw load button, active-low, asynchronous to CLOCK_50
- key_run_n  input  1  raw run button, active-low, asynchronous
- sw_instr  input  16  instruction word: [15:12] opcode, [11:8] rc, [7:4] ra/imm, [3:0] rb
- instr  output  16  head-of-FIFO instruction presented to the datapath
- instr_valid  output  1  instr is valid
- instr_ready  input  1  datapath accepts instr this cycle
- count  output  5  occupancy, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- busy  output  1  state == ISSUE
- err_overflow  output  1  sticky: a load was dropped because the FIFO was full
- err_opcode  output  1  sticky: a load was rejected because its opcode was > 10

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer. The debouncer emits a one-cycle pulse when the synchronized level has been low for DEBOUNCE_CYCLES consecutive cycles after having been high. A held button produces exactly one pulse.
- Load pulse handling:
  - If sw_instr[15:12] > 10: no push; err_opcode is set.
  - Else if full and no pop this cycle: no push; err_overflow is set.
  - Otherwise sw_instr is written at the write pointer.
- sw_instr is sampled in the cycle the load pulse occurs. The word is not latched at the press.
- FSM:
  - IDLE: on a run pulse with !empty, go to ISSUE. A run pulse while empty is ignored.
  - ISSUE: instr_valid = 1. A handshake (instr_valid && instr_ready) pops one entry. When a pop leaves count == 0, go to IDLE. A run pulse in ISSUE aborts: go to IDLE with the remaining entries retained.
- A load and a handshake in the same cycle are both performed and count is unchanged. This also applies when full: the pop frees a slot, so the push is accepted.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately so that full and empty are unambiguous.
- Sticky error flags clear only on reset.
- Reset values: state IDLE, pointers 0, count 0, empty 1, full 0, busy 0, instr_valid 0, instr 16'h0000, both error flags 0, debouncer counters 0, synchronizers 1 (released).

## Timing
- Button press to pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES.
- Push: count, full and empty update on the clock edge following the load pulse.
- Run pulse in IDLE: busy and instr_valid are 1 in the next cycle. instr is registered and equals the FIFO head in that same cycle.
- While instr_valid && !instr_ready, instr is held stable.
- After a handshake, the next entry is presented in the very next cycle, with no bubble. Sustained throughput is 1 instruction per cycle.
- Last handshake: instr_valid and busy are 0 in the next cycle.
- Abort: instr_valid drops in the next cycle. The un-accepted head entry stays in the FIFO.
- Reset asserted mid-ISSUE: the next cycle shows the reset values, the FIFO is emptied, and no further handshake is possible.

## Structure
- Shared package instr_pkg holds:
  - opcode constants OP_0..OP_10 and OP_MAX = 4'd10
  - field slice positions (OPC_MSB/LSB, RC, RA, RB)
  - emitter state enum {IDLE, ISSUE}
- Sub-module debounce_pulse (synchronizer + counter + falling-edge pulse, parameter DEBOUNCE_CYCLES) is instantiated twice, once per button.
- FIFO storage and the FSM live in instr_emitter itself.

## Test plan
All scenarios run with DEBOUNCE_CYCLES = 4 and DEPTH = 4.
- Load 16'h0123 then 16'h6A45, press run with instr_ready = 1 → instr = 0123 then 6A45 on consecutive cycles; busy falls the cycle after the second handshake; count returns to 0.
- Load 16'hB000 → no push, count stays 0, err_opcode = 1. Then load 16'hA000 → accepted, count = 1.
- Load 5 legal words → count = 4, full = 1, err_overflow = 1. Running drains the first 4 in load order.
- Hold instr_ready = 0 for 10 cycles during ISSUE → instr_valid = 1 and instr unchanged throughout. Then ready = 1 → handshake.
- Glitch key_load_n low for 2 cycles → no push. Hold it low for 100 cycles → exactly one push.
- With the FIFO full in ISSUE and ready = 1, issue a load pulse → count stays 4, no overflow error. Separately, assert reset_n = 0 mid-ISSUE → next cycle count = 0, instr_valid = 0, flags = 0.
